// File: rtl/segment_scanner.sv
// segment_scanner
// Multiplexed seven-segment display driver. One digit slot is 2^DIV clock
// cycles long and a frame visits all DIGITS slots in turn. Display data is
// double-buffered: a load strobe fills a shadow set, and the shadow is applied
// to the active set only at a frame boundary, so a frame never mixes old and
// new data. Brightness is PWM within each slot, taken from the top prescaler
// bits.
//
// Ports
//   clk_peripheral     in   sole clock
//   peripheral_resetn  in   asynchronous active-low reset, synchronous release
//   value              in   4*DIGITS  hex nibbles, digit DIGITS-1 most significant
//   dp                 in   DIGITS    decimal point per digit, 1 = lit
//   digit_en           in   DIGITS    1 = digit may light
//   blank_lz           in   1         leading-zero blanking enable
//   brightness         in   PWM_BITS  0 = dark, max = (2^PWM_BITS-1)/2^PWM_BITS duty
//   load               in   1         strobe capturing the five inputs above
//   pending            out  1         shadow holds data not yet applied
//   frame_done         out  1         one-cycle pulse at each frame boundary
//   an                 out  DIGITS    anode per digit
//   ca                 out  8         cathodes, bit7 dp, bits6:0 g..a
module segment_scanner #(
    parameter int DIGITS     = 8,
    parameter int DIV        = 12,
    parameter int PWM_BITS   = 3,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                  clk_peripheral,
    input  logic                  peripheral_resetn,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     digit_en,
    input  logic                  blank_lz,
    input  logic [PWM_BITS-1:0]   brightness,
    input  logic                  load,
    output logic                  pending,
    output logic                  frame_done,
    output logic [DIGITS-1:0]     an,
    output logic [7:0]            ca
);

    localparam int             IW       = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0]  LAST_IDX = IW'(DIGITS - 1);
    localparam logic           OFF_LVL  = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    logic [DIV-1:0]       r_pre;
    logic [IW-1:0]        r_idx;
    logic                 r_pending;
    logic                 r_frame_done;
    logic [DIGITS-1:0]    r_an;
    logic [7:0]           r_ca;

    logic [4*DIGITS-1:0]  r_sh_value;
    logic [DIGITS-1:0]    r_sh_dp;
    logic [DIGITS-1:0]    r_sh_en;
    logic                 r_sh_blz;
    logic [PWM_BITS-1:0]  r_sh_bright;

    logic [4*DIGITS-1:0]  r_act_value;
    logic [DIGITS-1:0]    r_act_dp;
    logic [DIGITS-1:0]    r_act_en;
    logic                 r_act_blz;
    logic [PWM_BITS-1:0]  r_act_bright;

    logic                 w_tick;
    logic                 w_boundary;
    logic [DIGITS-1:0]    w_blank;
    logic [3:0]           w_nib;
    logic [PWM_BITS-1:0]  w_level;
    logic                 w_lit;
    logic [DIGITS-1:0]    w_an_low;
    logic [7:0]           w_ca_low;

    function automatic logic [6:0] seg_font(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign w_tick     = &r_pre;
    assign w_boundary = w_tick && (r_idx == LAST_IDX);

    // Slot timing: free-running prescaler, digit index steps on its wrap.
    always_ff @(posedge clk_peripheral or negedge peripheral_resetn) begin
        if (!peripheral_resetn) begin
            r_pre <= '0;
            r_idx <= '0;
        end else begin
            r_pre <= r_pre + 1'b1;
            if (w_tick) begin
                r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_peripheral or negedge peripheral_resetn) begin
        if (!peripheral_resetn) begin
            r_sh_value  <= '0;
            r_sh_dp     <= '0;
            r_sh_en     <= '0;
            r_sh_blz    <= 1'b0;
            r_sh_bright <= '0;
        end else if (load) begin
            r_sh_value  <= value;
            r_sh_dp     <= dp;
            r_sh_en     <= digit_en;
            r_sh_blz    <= blank_lz;
            r_sh_bright <= brightness;
        end
    end

    // A load landing on the boundary bypasses the shadow so it is not
    // delayed by a whole frame.
    always_ff @(posedge clk_peripheral or negedge peripheral_resetn) begin
        if (!peripheral_resetn) begin
            r_act_value  <= '0;
            r_act_dp     <= '0;
            r_act_en     <= '0;
            r_act_blz    <= 1'b0;
            r_act_bright <= '0;
            r_pending    <= 1'b0;
        end else if (w_boundary) begin
            r_pending <= 1'b0;
            if (load) begin
                r_act_value  <= value;
                r_act_dp     <= dp;
                r_act_en     <= digit_en;
                r_act_blz    <= blank_lz;
                r_act_bright <= brightness;
            end else if (r_pending) begin
                r_act_value  <= r_sh_value;
                r_act_dp     <= r_sh_dp;
                r_act_en     <= r_sh_en;
                r_act_blz    <= r_sh_blz;
                r_act_bright <= r_sh_bright;
            end
        end else if (load) begin
            r_pending <= 1'b1;
        end
    end

    // Digit i is blanked when every nibble from the top down to i is zero.
    always_comb begin
        logic zero_run;
        w_blank  = '0;
        zero_run = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run & (r_act_value[4*i +: 4] == 4'h0);
            if (i > 0) begin
                w_blank[i] = r_act_blz & zero_run;
            end
        end
    end

    assign w_nib   = r_act_value[{r_idx, 2'b00} +: 4];
    assign w_level = r_pre[DIV-1 -: PWM_BITS];
    assign w_lit   = r_act_en[r_idx] && (w_level < r_act_bright) && !w_blank[r_idx];

    // Anode and cathodes come from the same idx/pre sample and are registered
    // together, so a new anode never carries the previous digit's pattern.
    assign w_an_low = w_lit ? ~({{(DIGITS-1){1'b0}}, 1'b1} << r_idx) : '1;
    assign w_ca_low = w_lit ? {~r_act_dp[r_idx], seg_font(w_nib)} : 8'hFF;

    always_ff @(posedge clk_peripheral or negedge peripheral_resetn) begin
        if (!peripheral_resetn) begin
            r_an         <= {DIGITS{OFF_LVL}};
            r_ca         <= {8{OFF_LVL}};
            r_frame_done <= 1'b0;
        end else begin
            r_an         <= (ACTIVE_LOW != 0) ? w_an_low : ~w_an_low;
            r_ca         <= (ACTIVE_LOW != 0) ? w_ca_low : ~w_ca_low;
            r_frame_done <= w_boundary;
        end
    end

    assign an         = r_an;
    assign ca         = r_ca;
    assign pending    = r_pending;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_segment_scanner.sv
// Bench for segment_scanner: instance A (4 digits, DIV 4, PWM 2, active-low)
// takes directed and random loads; instance B (5 digits, DIV 6, PWM 3,
// active-high) takes random loads throughout. Both are compared each cycle
// against a cycle-count based model of the display.
module tb_segment_scanner;

    typedef struct {
        logic [63:0] val;
        logic [15:0] dp;
        logic [15:0] en;
        logic        blz;
        int          bright;
    } cfg_t;

    typedef struct {
        cfg_t act;
        cfg_t sh;
        bit   pend;
        int   t;
    } mdl_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;

    logic [15:0] a_value = '0;
    logic [3:0]  a_dp = '0, a_en = '0;
    logic        a_blz = 1'b0, a_ld = 1'b0;
    logic [1:0]  a_br = '0;
    logic        a_pend, a_fd;
    logic [3:0]  a_an;
    logic [7:0]  a_ca;

    logic [19:0] b_value = '0;
    logic [4:0]  b_dp = '0, b_en = '0;
    logic        b_blz = 1'b0, b_ld = 1'b0;
    logic [2:0]  b_br = '0;
    logic        b_pend, b_fd;
    logic [4:0]  b_an;
    logic [7:0]  b_ca;

    int n_err = 0;
    int n_checks = 0;
    int a_lit [4];
    int a_f9 = 0;
    mdl_t ma, mb;
    logic [7:0] FONT [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                              8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    segment_scanner #(.DIGITS(4), .DIV(4), .PWM_BITS(2), .ACTIVE_LOW(1)) dut_a (
        .clk_peripheral(clk), .peripheral_resetn(rstn),
        .value(a_value), .dp(a_dp), .digit_en(a_en), .blank_lz(a_blz),
        .brightness(a_br), .load(a_ld), .pending(a_pend), .frame_done(a_fd),
        .an(a_an), .ca(a_ca));

    segment_scanner #(.DIGITS(5), .DIV(6), .PWM_BITS(3), .ACTIVE_LOW(0)) dut_b (
        .clk_peripheral(clk), .peripheral_resetn(rstn),
        .value(b_value), .dp(b_dp), .digit_en(b_en), .blank_lz(b_blz),
        .brightness(b_br), .load(b_ld), .pending(b_pend), .frame_done(b_fd),
        .an(b_an), .ca(b_ca));

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1, "timeout");
    end

    function automatic cfg_t cfg_zero();
        cfg_t c;
        c.val = '0; c.dp = '0; c.en = '0; c.blz = 1'b0; c.bright = 0;
        return c;
    endfunction

    function automatic mdl_t mdl_zero();
        mdl_t m;
        m.act = cfg_zero(); m.sh = cfg_zero(); m.pend = 1'b0; m.t = 0;
        return m;
    endfunction

    function automatic cfg_t mk(input logic [63:0] v, input logic [15:0] d,
                                input logic [15:0] e, input logic z, input int br);
        cfg_t c;
        c.val = v; c.dp = d; c.en = e; c.blz = z; c.bright = br;
        return c;
    endfunction

    // Display content for the cycle count t under active set a, at the pins.
    function automatic void expect_out(input cfg_t a, input int nd, input int div,
                                       input int pwb, input int al, input int t,
                                       output logic [15:0] an, output logic [7:0] ca);
        int slot, pre, idx, lvl;
        bit lit;
        logic [15:0] mask;
        slot = 1 << div;
        pre  = t % slot;
        idx  = (t / slot) % nd;
        lvl  = pre >> (div - pwb);
        lit  = a.en[idx] && (lvl < a.bright);
        if (idx > 0 && a.blz) begin
            bit allz = 1'b1;
            for (int i = idx; i < nd; i++) if (a.val[4*i +: 4] != 4'h0) allz = 1'b0;
            if (allz) lit = 1'b0;
        end
        an = lit ? ~(16'h0001 << idx) : 16'hFFFF;
        ca = lit ? {~a.dp[idx], FONT[a.val[4*idx +: 4]][6:0]} : 8'hFF;
        if (al == 0) begin
            an = ~an;
            ca = ~ca;
        end
        mask = (16'h0001 << nd) - 16'h0001;
        an = an & mask;
    endfunction

    function automatic void step(inout mdl_t m, input cfg_t live, input bit ld,
                                 input int frame, output bit bnd);
        m.t++;
        bnd = (m.t % frame) == 0;
        if (bnd) begin
            if (ld) m.act = live;
            else if (m.pend) m.act = m.sh;
        end
        if (ld) m.sh = live;
        m.pend = bnd ? 1'b0 : (ld ? 1'b1 : m.pend);
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        logic [15:0] ea_an, eb_an;
        logic [7:0]  ea_ca, eb_ca;
        bit bnd_a, bnd_b, lda, ldb;
        cfg_t la, lb;
        if ($urandom_range(0, 49) == 0) begin
            b_value = 20'($urandom);
            b_dp    = 5'($urandom);
            b_en    = 5'($urandom);
            b_blz   = 1'($urandom);
            b_br    = 3'($urandom);
            b_ld    = 1'b1;
        end
        expect_out(ma.act, 4, 4, 2, 1, ma.t, ea_an, ea_ca);
        expect_out(mb.act, 5, 6, 3, 0, mb.t, eb_an, eb_ca);
        la  = mk(64'(a_value), 16'(a_dp), 16'(a_en), a_blz, int'(a_br));
        lb  = mk(64'(b_value), 16'(b_dp), 16'(b_en), b_blz, int'(b_br));
        lda = a_ld;
        ldb = b_ld;
        @(posedge clk);
        if (!rstn) begin
            ma = mdl_zero(); mb = mdl_zero();
            bnd_a = 1'b0; bnd_b = 1'b0;
        end else begin
            step(ma, la, lda, 64, bnd_a);
            step(mb, lb, ldb, 320, bnd_b);
        end
        @(negedge clk);
        chk("a_an", 16'(a_an), ea_an);
        chk("a_ca", 16'(a_ca), 16'(ea_ca));
        chk("a_pending", 16'(a_pend), 16'(ma.pend));
        chk("a_frame_done", 16'(a_fd), 16'(bnd_a));
        chk("b_an", 16'(b_an), eb_an);
        chk("b_ca", 16'(b_ca), 16'(eb_ca));
        chk("b_pending", 16'(b_pend), 16'(mb.pend));
        chk("b_frame_done", 16'(b_fd), 16'(bnd_b));
        for (int i = 0; i < 4; i++) if (a_an[i] == 1'b0) a_lit[i]++;
        if (a_an != 4'hF && a_ca == 8'hF9) a_f9++;
        a_ld = 1'b0;
        b_ld = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic to_boundary();
        for (int i = 0; i < 400 && (ma.t % 64) != 0; i++) cycle();
    endtask

    task automatic clear_tally();
        for (int i = 0; i < 4; i++) a_lit[i] = 0;
        a_f9 = 0;
    endtask

    task automatic load_a(input logic [15:0] v, input logic [3:0] d, input logic [3:0] e,
                          input logic z, input logic [1:0] br);
        a_value = v; a_dp = d; a_en = e; a_blz = z; a_br = br; a_ld = 1'b1;
        cycle();
    endtask

    // Load, wait for it to take effect, then tally one whole frame.
    task automatic show_frame(input logic [15:0] v, input logic [3:0] d, input logic [3:0] e,
                              input logic z, input logic [1:0] br);
        load_a(v, d, e, z, br);
        to_boundary();
        clear_tally();
        run(64);
    endtask

    initial begin
        ma = mdl_zero();
        mb = mdl_zero();
        clear_tally();

        // Reset held: inputs and load toggle, outputs stay off.
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            a_value = 16'($urandom); a_br = 2'd3; a_en = 4'hF; a_ld = 1'($urandom);
            cycle();
        end
        chk("rst_a_an", 16'(a_an), 16'h000F);
        chk("rst_a_ca", 16'(a_ca), 16'h00FF);
        chk("rst_a_pending", 16'(a_pend), 16'h0000);

        rstn = 1'b1;
        a_value = '0; a_br = '0; a_en = '0;
        clear_tally();
        run(150);
        chk("dark_after_reset", 16'(a_lit[0] + a_lit[1] + a_lit[2] + a_lit[3]), 16'd0);

        // Basic scan.
        load_a(16'h1234, 4'h0, 4'hF, 1'b0, 2'd3);
        chk("basic_pending_set", 16'(a_pend), 16'h0001);
        to_boundary();
        chk("basic_frame_done", 16'(a_fd), 16'h0001);
        chk("basic_pending_clr", 16'(a_pend), 16'h0000);
        clear_tally();
        run(64);
        for (int i = 0; i < 4; i++) chk("basic_lit12", 16'(a_lit[i]), 16'd12);

        // Leading-zero blanking.
        show_frame(16'h0040, 4'h8, 4'hF, 1'b1, 2'd3);
        chk("blank_d3", 16'(a_lit[3]), 16'd0);
        chk("blank_d2", 16'(a_lit[2]), 16'd0);
        chk("blank_d1", 16'(a_lit[1]), 16'd12);
        chk("blank_d0", 16'(a_lit[0]), 16'd12);
        show_frame(16'h0000, 4'h0, 4'hF, 1'b1, 2'd3);
        chk("zero_d0", 16'(a_lit[0]), 16'd12);
        chk("zero_rest", 16'(a_lit[1] + a_lit[2] + a_lit[3]), 16'd0);

        // Double buffer: the overwritten load never reaches the pins.
        clear_tally();
        load_a(16'h1111, 4'h0, 4'hF, 1'b0, 2'd3);
        run(20);
        load_a(16'h2222, 4'h0, 4'hF, 1'b0, 2'd3);
        to_boundary();
        run(64);
        chk("dbuf_no_1111", 16'(a_f9), 16'd0);

        // Load exactly on the boundary cycle.
        for (int i = 0; i < 100 && ((ma.t + 1) % 64) != 0; i++) cycle();
        load_a(16'h5678, 4'h3, 4'hF, 1'b0, 2'd3);
        chk("bnd_load_pending", 16'(a_pend), 16'h0000);
        chk("bnd_load_fd", 16'(a_fd), 16'h0001);

        // Brightness and digit enable.
        show_frame(16'h9ABC, 4'h0, 4'hF, 1'b0, 2'd0);
        chk("bright0", 16'(a_lit[0] + a_lit[1] + a_lit[2] + a_lit[3]), 16'd0);
        show_frame(16'h9ABC, 4'h0, 4'hF, 1'b0, 2'd1);
        for (int i = 0; i < 4; i++) chk("bright1_lit4", 16'(a_lit[i]), 16'd4);
        show_frame(16'hDEF0, 4'hF, 4'h5, 1'b0, 2'd3);
        chk("en5_d1", 16'(a_lit[1]), 16'd0);
        chk("en5_d3", 16'(a_lit[3]), 16'd0);
        chk("en5_d0", 16'(a_lit[0]), 16'd12);

        // Random loads at random times.
        for (int k = 0; k < 25; k++) begin
            a_value = 16'($urandom); a_dp = 4'($urandom); a_en = 4'($urandom);
            a_blz = 1'($urandom); a_br = 2'($urandom); a_ld = 1'b1;
            cycle();
            run($urandom_range(1, 150));
        end

        // Asynchronous reset mid-slot.
        load_a(16'h8888, 4'hF, 4'hF, 1'b0, 2'd3);
        to_boundary();
        run(5);
        #2 rstn = 1'b0;
        #1;
        ma = mdl_zero();
        mb = mdl_zero();
        chk("async_a_an", 16'(a_an), 16'h000F);
        chk("async_a_ca", 16'(a_ca), 16'h00FF);
        chk("async_a_pending", 16'(a_pend), 16'h0000);
        chk("async_b_an", 16'(b_an), 16'h0000);
        chk("async_b_ca", 16'(b_ca), 16'h0000);
        @(negedge clk);
        run(3);
        rstn = 1'b1;
        run(700);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
